// File: rtl/enet_pkg.sv
// Shared state encodings and byte constants for the GMII TX arbiter.
package enet_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SFD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_PAD      = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;
    localparam logic [2:0] ST_IPG      = 3'd6;

    localparam logic [7:0]  ENET_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ENET_SFD_BYTE      = 8'hD5;
    localparam logic [10:0] ENET_BYTE_CNT_MAX  = 11'd2047;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == ENET_BYTE_CNT_MAX) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/enet_rr_arb2.sv
// Two-way round-robin grant; the pointer only moves when the owner pulses i_update.
module enet_rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_update_id,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    logic r_last;

    // Reset to 1 so source 0 wins the first contest.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_update_id;
        end
    end

    always_comb begin
        o_grant_valid = |i_req;
        if (&i_req) begin
            o_grant_id = ~r_last;
        end else begin
            o_grant_id = i_req[1];
        end
    end

endmodule

// File: rtl/enet_gmii_tx_arbiter.sv
// Shares the GMII TX port between two frame sources at frame granularity.
// Short-frame padding is built only when ENET_TX_PAD_EN is defined.
module enet_gmii_tx_arbiter
    import enet_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned IPG_BYTES       = 12,
    parameter int unsigned MIN_FRAME_BYTES = 60
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic       o_gmii_tx_en,
    output logic       o_gmii_tx_er,
    output logic [7:0] o_gmii_txd,
    output logic       o_busy,
    output logic       o_grant_id,
    output logic       o_underrun
);

    localparam logic [4:0] PRE_LAST = 5'(PREAMBLE_BYTES - 1);
    localparam logic [4:0] IPG_LAST = 5'(IPG_BYTES - 1);
`ifdef ENET_TX_PAD_EN
    localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_BYTES);
`endif

    logic [2:0]  r_state, w_state_d;
    logic [4:0]  r_cnt, w_cnt_d;
    logic [10:0] r_byte_cnt, w_byte_cnt_d, w_cnt_inc;
    logic        r_grant_id, w_grant_d;
    logic        r_tx_en, r_tx_er, r_underrun;
    logic [7:0]  r_txd;
    logic        w_tx_en_d, w_tx_er_d, w_underrun_d;
    logic [7:0]  w_txd_d;
    logic        w_arb_valid, w_arb_id, w_ptr_upd;
    logic        w_src_valid, w_src_last, w_rdy_open;
    logic [7:0]  w_src_data;

    enet_rr_arb2 u_arb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        ({i_req1_valid, i_req0_valid}),
        .i_update     (w_ptr_upd),
        .i_update_id  (r_grant_id),
        .o_grant_valid(w_arb_valid),
        .o_grant_id   (w_arb_id)
    );

    assign w_src_valid = r_grant_id ? i_req1_valid : i_req0_valid;
    assign w_src_data  = r_grant_id ? i_req1_data  : i_req0_data;
    assign w_src_last  = r_grant_id ? i_req1_last  : i_req0_last;
    assign w_cnt_inc   = sat_inc11(r_byte_cnt);

    // Gated by reset so nothing is handshaken during a reset cycle.
    assign w_rdy_open   = ((r_state == ST_DATA) || (r_state == ST_DRAIN)) && i_rst_n;
    assign o_req0_ready = w_rdy_open && !r_grant_id;
    assign o_req1_ready = w_rdy_open && r_grant_id;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_byte_cnt_d = r_byte_cnt;
        w_grant_d    = r_grant_id;
        w_tx_en_d    = 1'b0;
        w_tx_er_d    = 1'b0;
        w_txd_d      = 8'h00;
        w_underrun_d = 1'b0;
        w_ptr_upd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_d      = '0;
                w_byte_cnt_d = '0;
                if (w_arb_valid) begin
                    w_grant_d = w_arb_id;
                    w_state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                w_tx_en_d = 1'b1;
                w_txd_d   = ENET_PREAMBLE_BYTE;
                if (r_cnt == PRE_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_SFD;
                end else begin
                    w_cnt_d = r_cnt + 5'd1;
                end
            end
            ST_SFD: begin
                w_tx_en_d = 1'b1;
                w_txd_d   = ENET_SFD_BYTE;
                w_state_d = ST_DATA;
            end
            ST_DATA: begin
                w_tx_en_d = 1'b1;
                if (w_src_valid) begin
                    w_txd_d      = w_src_data;
                    w_byte_cnt_d = w_cnt_inc;
                    if (w_src_last) begin
`ifdef ENET_TX_PAD_EN
                        if (w_cnt_inc < MIN_LEN) begin
                            w_state_d = ST_PAD;
                        end else begin
                            w_state_d = ST_IPG;
                            w_ptr_upd = 1'b1;
                        end
`else
                        w_state_d = ST_IPG;
                        w_ptr_upd = 1'b1;
`endif
                    end
                end else begin
                    w_tx_er_d    = 1'b1;
                    w_underrun_d = 1'b1;
                    w_state_d    = ST_DRAIN;
                end
            end
`ifdef ENET_TX_PAD_EN
            ST_PAD: begin
                w_tx_en_d    = 1'b1;
                w_byte_cnt_d = w_cnt_inc;
                if (w_cnt_inc >= MIN_LEN) begin
                    w_state_d = ST_IPG;
                    w_ptr_upd = 1'b1;
                end
            end
`endif
            ST_DRAIN: begin
                if (w_src_valid && w_src_last) begin
                    w_state_d = ST_IPG;
                    w_ptr_upd = 1'b1;
                end
            end
            ST_IPG: begin
                if (r_cnt == IPG_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = ST_IDLE;
                end else begin
                    w_cnt_d = r_cnt + 5'd1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_byte_cnt <= '0;
            r_grant_id <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_txd      <= 8'h00;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_byte_cnt <= w_byte_cnt_d;
            r_grant_id <= w_grant_d;
            r_tx_en    <= w_tx_en_d;
            r_tx_er    <= w_tx_er_d;
            r_txd      <= w_txd_d;
            r_underrun <= w_underrun_d;
        end
    end

    assign o_gmii_tx_en = r_tx_en;
    assign o_gmii_tx_er = r_tx_er;
    assign o_gmii_txd   = r_txd;
    assign o_underrun   = r_underrun;
    assign o_grant_id   = r_grant_id;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_enet_gmii_tx_arbiter.sv
// Bench for enet_gmii_tx_arbiter: frame-level model builds the expected per-cycle trace.
module tb_enet_gmii_tx_arbiter;

    localparam int PRE  = 7;
    localparam int IPG  = 12;
    localparam int MINF = 60;

    typedef struct packed {
        logic       busy;
        logic       gid;
        logic [1:0] rdy;
        logic       en;
        logic       er;
        logic [7:0] d;
        logic       und;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] vld;
    logic [1:0] lst;
    logic [7:0] dat [2];
    logic       o_req0_ready, o_req1_ready, o_gmii_tx_en, o_gmii_tx_er;
    logic [7:0] o_gmii_txd;
    logic       o_busy, o_grant_id, o_underrun;

    always #4 clk = ~clk;

    enet_gmii_tx_arbiter u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req0_valid(vld[0]),
        .i_req0_data (dat[0]),
        .i_req0_last (lst[0]),
        .o_req0_ready(o_req0_ready),
        .i_req1_valid(vld[1]),
        .i_req1_data (dat[1]),
        .i_req1_last (lst[1]),
        .o_req1_ready(o_req1_ready),
        .o_gmii_tx_en(o_gmii_tx_en),
        .o_gmii_tx_er(o_gmii_tx_er),
        .o_gmii_txd  (o_gmii_txd),
        .o_busy      (o_busy),
        .o_grant_id  (o_grant_id),
        .o_underrun  (o_underrun)
    );

    int checks = 0;
    int failures = 0;

    // Staged frames (model input) and per-source driver state.
    int         st_len [2][$];
    int         st_k   [2][$];
    int         st_g   [2][$];
    logic [7:0] st_b   [2][$];
    logic [7:0] dv_b   [2][$];
    bit         dv_l   [2][$];
    int         dv_k   [2][$];
    int         dv_g   [2][$];
    int         idx    [2];
    bit         gdone  [2];
    int         grem   [2];

    ent_t exp_q[$];
    ent_t prv;
    ent_t ce;
    bit   chk = 1'b0;
    bit   m_ptr = 1'b1;
    bit   m_gid = 1'b0;
    int   ph_cyc, ph_en, ph_und, ph_first;
    logic [14:0] got, want, mask;

    // Each entry gives busy/grant/ready for its own cycle and the byte that shows up next cycle.
    always @(negedge clk) begin
        if (chk) begin
            mask = '1;
            if (exp_q.size() > 0) begin
                ce = exp_q.pop_front();
            end else begin
                ce = '0;
                mask[13] = 1'b0;
            end
            got  = {o_busy, o_grant_id, o_req1_ready, o_req0_ready, o_gmii_tx_en, o_gmii_tx_er,
                    o_gmii_txd, o_underrun};
            want = {ce.busy, ce.gid, ce.rdy, prv.en, prv.er, prv.d, prv.und};
            checks++;
            if (((got ^ want) & mask) != '0) begin
                failures++;
                if (failures < 30)
                    $display("FAIL cycle_trace t=%0t got=%h want=%h mask=%h", $time, got, want, mask);
            end
            prv = ce;
            if (o_gmii_tx_en) begin
                ph_en++;
                if (ph_first < 0) ph_first = ph_cyc;
            end
            if (o_underrun) ph_und++;
            ph_cyc++;
        end
    end

    task automatic chk_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, req);
        end
    endtask

    function automatic void update_src(input int s, input bit acc);
        bit was_last;
        if (acc) begin
            was_last = dv_l[s][0];
            void'(dv_b[s].pop_front());
            void'(dv_l[s].pop_front());
            idx[s]++;
            if (was_last) begin
                void'(dv_k[s].pop_front());
                void'(dv_g[s].pop_front());
                idx[s]   = 0;
                gdone[s] = 1'b0;
            end
        end
        if (dv_k[s].size() > 0 && dv_k[s][0] != 0 && idx[s] == dv_k[s][0] && !gdone[s]) begin
            grem[s]  = dv_g[s][0];
            gdone[s] = 1'b1;
        end
        if (grem[s] > 0) begin
            vld[s] = 1'b0;
            grem[s]--;
        end else begin
            vld[s] = (dv_b[s].size() > 0);
        end
        if (dv_b[s].size() > 0) begin
            dat[s] = dv_b[s][0];
            lst[s] = dv_l[s][0];
        end else begin
            dat[s] = 8'h00;
            lst[s] = 1'b0;
        end
    endfunction

    task automatic tick();
        bit a0, a1;
        @(negedge clk);
        a0 = vld[0] && o_req0_ready;
        a1 = vld[1] && o_req1_ready;
        @(posedge clk);
        #1;
        update_src(0, a0);
        update_src(1, a1);
    endtask

    task automatic add_frame(input int s, input int len, input int k, input int g, input bit inc);
        st_len[s].push_back(len);
        st_k[s].push_back(k);
        st_g[s].push_back(g);
        for (int j = 0; j < len; j++) st_b[s].push_back(inc ? 8'(j + 1) : 8'($urandom));
    endtask

    task automatic load_drivers();
        int off;
        for (int s = 0; s < 2; s++) begin
            off = 0;
            for (int f = 0; f < st_len[s].size(); f++) begin
                dv_k[s].push_back(st_k[s][f]);
                dv_g[s].push_back(st_g[s][f]);
                for (int j = 0; j < st_len[s][f]; j++) begin
                    dv_b[s].push_back(st_b[s][off + j]);
                    dv_l[s].push_back(j == st_len[s][f] - 1);
                end
                off += st_len[s][f];
            end
            st_len[s].delete();
            st_k[s].delete();
            st_g[s].delete();
            st_b[s].delete();
        end
        update_src(0, 1'b0);
        update_src(1, 1'b0);
    endtask

    function automatic void pushe(input bit busy, input bit gid, input logic [1:0] rdy,
                                  input bit en, input bit er, input logic [7:0] d, input bit und);
        ent_t e;
        e.busy = busy; e.gid = gid; e.rdy = rdy; e.en = en; e.er = er; e.d = d; e.und = und;
        exp_q.push_back(e);
    endfunction

    // Called at posedge+1 with the DUT idle: builds the whole expected trace, then starts sources.
    task automatic run_phase(input int budget);
        int fi [2];
        int off [2];
        int s, len, k, g, n;
        logic [1:0] rd;
        bit p;
        ph_cyc = 0; ph_en = 0; ph_und = 0; ph_first = -1;
        fi[0] = 0; fi[1] = 0; off[0] = 0; off[1] = 0;
        p = m_ptr;
        pushe(1'b0, m_gid, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
        while (fi[0] < st_len[0].size() || fi[1] < st_len[1].size()) begin
            if (fi[0] < st_len[0].size() && fi[1] < st_len[1].size()) s = p ? 0 : 1;
            else s = (fi[0] < st_len[0].size()) ? 0 : 1;
            p = bit'(s);
            m_gid = bit'(s);
            len = st_len[s][fi[s]];
            k = st_k[s][fi[s]];
            g = st_g[s][fi[s]];
            rd = (s == 1) ? 2'b10 : 2'b01;
            repeat (PRE) pushe(1'b1, m_gid, 2'b00, 1'b1, 1'b0, 8'h55, 1'b0);
            pushe(1'b1, m_gid, 2'b00, 1'b1, 1'b0, 8'hD5, 1'b0);
            if (k == 0) begin
                for (int j = 0; j < len; j++)
                    pushe(1'b1, m_gid, rd, 1'b1, 1'b0, st_b[s][off[s] + j], 1'b0);
`ifdef ENET_TX_PAD_EN
                for (int j = len; j < MINF; j++)
                    pushe(1'b1, m_gid, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
`endif
            end else begin
                for (int j = 0; j < k; j++)
                    pushe(1'b1, m_gid, rd, 1'b1, 1'b0, st_b[s][off[s] + j], 1'b0);
                pushe(1'b1, m_gid, rd, 1'b1, 1'b1, 8'h00, 1'b1);
                repeat (g - 1 + len - k) pushe(1'b1, m_gid, rd, 1'b0, 1'b0, 8'h00, 1'b0);
            end
            repeat (IPG) pushe(1'b1, m_gid, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
            pushe(1'b0, m_gid, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0);
            off[s] += len;
            fi[s]++;
        end
        m_ptr = p;
        load_drivers();
        n = 0;
        while ((exp_q.size() > 0 || dv_b[0].size() > 0 || dv_b[1].size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk_eq("phase_done_in_budget", (n < budget) ? 1 : 0, 1);
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, len, k, g;
        vld = 2'b00; lst = 2'b00; dat[0] = 8'h00; dat[1] = 8'h00;
        for (int s = 0; s < 2; s++) begin
            idx[s] = 0; gdone[s] = 1'b0; grem[s] = 0;
        end
        prv = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("reset_outputs", int'({o_busy, o_grant_id, o_req1_ready, o_req0_ready, o_gmii_tx_en,
                                      o_gmii_tx_er, o_gmii_txd, o_underrun}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk = 1'b1;
        repeat (3) tick();

        // Single 64-byte frame from source 0.
        add_frame(0, 64, 0, 0, 1'b1);
        run_phase(400);
        chk_eq("first_tx_en_latency", ph_first, 2);
        chk_eq("single_frame_en_cycles", ph_en, 72);

        // Three frames from each source, all pending together.
        for (int f = 0; f < 3; f++) begin
            add_frame(0, 64, 0, 0, 1'b0);
            add_frame(1, 64, 0, 0, 1'b0);
        end
        run_phase(1200);
        chk_eq("six_frames_en_cycles", ph_en, 432);

        // Source 1 stalls after 10 of 40 bytes.
        add_frame(1, 40, 10, 3, 1'b1);
        run_phase(400);
        chk_eq("underrun_en_cycles", ph_en, 19);
        chk_eq("underrun_pulses", ph_und, 1);

        // Short frame: padded to the minimum only when the feature is built.
        add_frame(0, 20, 0, 0, 1'b1);
        run_phase(400);
`ifdef ENET_TX_PAD_EN
        chk_eq("short_frame_en_cycles", ph_en, 68);
`else
        chk_eq("short_frame_en_cycles", ph_en, 28);
`endif

        // Reset for one cycle in the middle of source 1's data.
        chk = 1'b0;
        add_frame(1, 30, 0, 0, 1'b1);
        load_drivers();
        repeat (15) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            dv_b[s].delete(); dv_l[s].delete(); dv_k[s].delete(); dv_g[s].delete();
            idx[s] = 0; gdone[s] = 1'b0; grem[s] = 0;
        end
        vld = 2'b00; lst = 2'b00;
        @(negedge clk);
        chk_eq("reset_mid_frame", int'({o_busy, o_grant_id, o_req1_ready, o_req0_ready, o_gmii_tx_en,
                                        o_gmii_tx_er, o_gmii_txd, o_underrun}), 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        prv = '0;
        m_ptr = 1'b1;
        m_gid = 1'b0;
        chk = 1'b1;
        add_frame(0, 25, 0, 0, 1'b0);
        add_frame(1, 25, 0, 0, 1'b0);
        run_phase(600);

        // Randomised mixes of frame counts, lengths and underruns.
        for (int r = 0; r < 6; r++) begin
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            if (n0 == 0 && n1 == 0) n0 = 1;
            for (int s = 0; s < 2; s++) begin
                for (int f = 0; f < ((s == 0) ? n0 : n1); f++) begin
                    len = $urandom_range(1, 90);
                    k = 0;
                    g = 0;
                    if (len >= 2 && $urandom_range(0, 4) == 0) begin
                        k = $urandom_range(1, len - 1);
                        g = $urandom_range(1, 4);
                    end
                    add_frame(s, len, k, g, 1'b0);
                end
            end
            run_phase(1500);
        end

        // Frame longer than the byte counter range.
        add_frame(1, 2100, 0, 0, 1'b0);
        run_phase(2500);
        chk_eq("long_frame_en_cycles", ph_en, 2108);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
